// File: rtl/add_round_key_stream.sv
// Two-stage streaming AddRoundKey with a local round-key store and valid/ready on both sides.
// Optional key-fault checking is enabled by defining ARK_KEYCHK_EN.
module add_round_key_stream #(
    parameter int unsigned DATA_W   = 128,
    parameter int unsigned NUM_KEYS = 15,
    parameter int unsigned KIDX_W   = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Kwr_En,
    input  logic [KIDX_W-1:0] Kwr_Idx,
    input  logic [DATA_W-1:0] Kwr_Data,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [DATA_W-1:0] In_Data,
    input  logic [KIDX_W-1:0] In_KIdx,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [DATA_W-1:0] Out_Data,
    output logic [CNT_W-1:0]  Blk_Cnt,
    output logic              Key_Err
);

    localparam logic [KIDX_W:0] NUM_KEYS_X = (KIDX_W + 1)'(NUM_KEYS);

    logic [DATA_W-1:0] key_q [NUM_KEYS];
    logic [DATA_W-1:0] key_d [NUM_KEYS];
    logic              v1_q, v1_d, v2_q, v2_d;
    logic [DATA_W-1:0] d1_q, d1_d, k1_q, k1_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              adv1, adv2, accept;
    logic              kwr_ok, in_ok, hit;
    logic [DATA_W-1:0] sel_key;

`ifdef ARK_KEYCHK_EN
    logic [(2**KIDX_W)-1:0] loaded_q, loaded_d;
    logic                   err1_q, err1_d;
    logic                   key_err_q, key_err_d;
`endif

    assign adv2     = !v2_q || Out_Ready;
    assign adv1     = !v1_q || adv2;
    assign accept   = In_Valid && adv1;
    assign In_Ready = adv1;

    assign Out_Valid = v2_q;
    assign Out_Data  = out_q;
    assign Blk_Cnt   = cnt_q;

    // Key store update, write-bypassed key select, and pipeline advance.
    always_comb begin
        key_d   = key_q;
        v1_d    = v1_q;
        d1_d    = d1_q;
        k1_d    = k1_q;
        v2_d    = v2_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        kwr_ok  = Kwr_En && ({1'b0, Kwr_Idx} < NUM_KEYS_X);
        in_ok   = {1'b0, In_KIdx} < NUM_KEYS_X;
        hit     = kwr_ok && (Kwr_Idx == In_KIdx);
        sel_key = '0;

        if (in_ok) begin
            sel_key = hit ? Kwr_Data : key_q[In_KIdx];
        end
        if (kwr_ok) begin
            key_d[Kwr_Idx] = Kwr_Data;
        end

        if (adv1) begin
            v1_d = In_Valid;
        end
        if (accept) begin
            d1_d = In_Data;
            k1_d = sel_key;
        end

        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                out_d = d1_q ^ k1_q;
            end
        end

        if (v2_q && Out_Ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

`ifdef ARK_KEYCHK_EN
    // Fault bit rides with the block and joins the sticky flag as the block reaches the output.
    always_comb begin
        loaded_d  = loaded_q;
        err1_d    = err1_q;
        key_err_d = key_err_q;
        if (kwr_ok) begin
            loaded_d[Kwr_Idx] = 1'b1;
        end
        if (accept) begin
            err1_d = !(in_ok && (loaded_q[In_KIdx] || hit));
        end
        if (adv2 && v1_q && err1_q) begin
            key_err_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            loaded_q  <= '0;
            err1_q    <= 1'b0;
            key_err_q <= 1'b0;
        end else begin
            loaded_q  <= loaded_d;
            err1_q    <= err1_d;
            key_err_q <= key_err_d;
        end
    end

    assign Key_Err = key_err_q;
`else
    assign Key_Err = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < int'(NUM_KEYS); i++) begin
                key_q[i] <= '0;
            end
            v1_q  <= 1'b0;
            d1_q  <= '0;
            k1_q  <= '0;
            v2_q  <= 1'b0;
            out_q <= '0;
            cnt_q <= '0;
        end else begin
            key_q <= key_d;
            v1_q  <= v1_d;
            d1_q  <= d1_d;
            k1_q  <= k1_d;
            v2_q  <= v2_d;
            out_q <= out_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_add_round_key_stream.sv
// Randomised self-checking bench for add_round_key_stream against a queue-based reference model.
module tb_add_round_key_stream;

    logic         Clk;
    logic         Rst_n;
    logic         Kwr_En;
    logic [3:0]   Kwr_Idx;
    logic [127:0] Kwr_Data;
    logic         In_Valid;
    logic         In_Ready;
    logic [127:0] In_Data;
    logic [3:0]   In_KIdx;
    logic         Out_Valid;
    logic         Out_Ready;
    logic [127:0] Out_Data;
    logic [15:0]  Blk_Cnt;
    logic         Key_Err;

    add_round_key_stream dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .Kwr_En(Kwr_En), .Kwr_Idx(Kwr_Idx), .Kwr_Data(Kwr_Data),
        .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Data(In_Data), .In_KIdx(In_KIdx),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Data(Out_Data),
        .Blk_Cnt(Blk_Cnt), .Key_Err(Key_Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [127:0] d;
        bit           bad;
    } exp_t;

    logic [127:0] mkey [15];
    bit           mload [15];
    exp_t         q [$];
    logic [15:0]  cnt_model;
    bit           err_seen;
    int           checks;
    int           failures;
    logic         s_in_ready, s_out_valid;
    logic [127:0] s_out_data, last_out;
    int           n_out;

    localparam logic [127:0] ONES = {128{1'b1}};

    task automatic model_clear();
        for (int i = 0; i < 15; i++) begin
            mkey[i]  = '0;
            mload[i] = 1'b0;
        end
        q.delete();
        cnt_model = '0;
        err_seen  = 1'b0;
    endtask

    // One clock: drive at negedge, predict and score the transfers of this cycle, advance.
    task automatic run_cycle(input logic kv, input logic [3:0] kidx, input logic [127:0] kd,
                             input logic iv, input logic [127:0] id, input logic [3:0] iidx,
                             input logic ordy);
        exp_t         e;
        logic [127:0] k;
        bit           bad;
        bit           exp_err;
        bit           exp_rdy;
        Kwr_En = kv; Kwr_Idx = kidx; Kwr_Data = kd;
        In_Valid = iv; In_Data = id; In_KIdx = iidx;
        Out_Ready = ordy;
        #1;
        s_in_ready  = In_Ready;
        s_out_valid = Out_Valid;
        s_out_data  = Out_Data;

        exp_rdy = !(q.size() == 2 && !ordy);
        checks++;
        if (In_Ready !== exp_rdy) begin
            failures++;
            $display("FAIL in_ready: got %b want %b (in flight %0d)", In_Ready, exp_rdy, q.size());
        end

        exp_err = err_seen || (Out_Valid && q.size() > 0 && q[0].bad);
`ifndef ARK_KEYCHK_EN
        exp_err = 1'b0;
`endif
        checks++;
        if (Key_Err !== exp_err) begin
            failures++;
            $display("FAIL key_err: got %b want %b", Key_Err, exp_err);
        end

        if (Out_Valid && ordy) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL out_unexpected: got %h want no transfer", Out_Data);
            end else begin
                e = q.pop_front();
                if (Out_Data !== e.d) begin
                    failures++;
                    $display("FAIL out_data: got %h want %h", Out_Data, e.d);
                end
                err_seen = err_seen || e.bad;
            end
            last_out  = Out_Data;
            cnt_model = cnt_model + 16'd1;
            n_out++;
        end

        if (iv && In_Ready) begin
            k   = '0;
            bad = (iidx >= 4'd15);
            if (!bad) begin
                if (kv && kidx == iidx) begin
                    k = kd;
                end else begin
                    k   = mkey[iidx];
                    bad = !mload[iidx];
                end
            end
            e.d   = id ^ k;
            e.bad = bad;
            q.push_back(e);
        end
        if (kv && kidx < 4'd15) begin
            mkey[kidx]  = kd;
            mload[kidx] = 1'b1;
        end
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic idle(input logic ordy);
        run_cycle(1'b0, 4'd0, '0, 1'b0, '0, 4'd0, ordy);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() != 0; i++) idle(1'b1);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d blocks left want 0", q.size());
        end
    endtask

    task automatic do_reset();
        Kwr_En = 0; In_Valid = 0; Out_Ready = 1;
        Rst_n = 1'b0;
        model_clear();
        @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        Kwr_En = 0; Kwr_Idx = 0; Kwr_Data = 0;
        In_Valid = 0; In_Data = 0; In_KIdx = 0; Out_Ready = 1;
        Rst_n = 1'b0;
        model_clear();
        #3;
        checks += 4;
        if (Out_Valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b want 0", Out_Valid); end
        if (Out_Data !== '0)    begin failures++; $display("FAIL rst_out_data: got %h want 0", Out_Data); end
        if (Blk_Cnt !== 16'd0)  begin failures++; $display("FAIL rst_blk_cnt: got %0d want 0", Blk_Cnt); end
        if (Key_Err !== 1'b0)   begin failures++; $display("FAIL rst_key_err: got %b want 0", Key_Err); end
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        checks++;
        if (In_Ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b want 1", In_Ready); end
        @(negedge Clk);
    endtask

    task automatic test_fips();
        logic [127:0] key, pt, ct;
        key = 128'h000102030405060708090a0b0c0d0e0f;
        pt  = 128'h00112233445566778899aabbccddeeff;
        ct  = 128'h00102030405060708090a0b0c0d0e0f0;
        run_cycle(1'b1, 4'd0, key, 1'b0, '0, 4'd0, 1'b1);
        run_cycle(1'b0, 4'd0, '0, 1'b1, pt, 4'd0, 1'b1);
        #1;
        checks++;
        if (Out_Valid !== 1'b0) begin failures++; $display("FAIL fips_early: got %b want 0", Out_Valid); end
        idle(1'b1);
        #1;
        checks += 2;
        if (Out_Valid !== 1'b1) begin failures++; $display("FAIL fips_latency: got %b want 1", Out_Valid); end
        if (Out_Data !== ct)    begin failures++; $display("FAIL fips_data: got %h want %h", Out_Data, ct); end
        idle(1'b1);
        checks++;
        if (Blk_Cnt !== 16'd1) begin failures++; $display("FAIL fips_cnt: got %0d want 1", Blk_Cnt); end
    endtask

    task automatic test_throughput();
        logic [15:0] cnt0;
        int          out0;
        for (int i = 0; i < 15; i++) run_cycle(1'b1, 4'(i), rnd128(), 1'b0, '0, 4'd0, 1'b1);
        cnt0 = Blk_Cnt;
        out0 = n_out;
        for (int i = 0; i < 22; i++) begin
            run_cycle(1'b0, 4'd0, '0, i < 20, rnd128(), 4'($urandom_range(0, 14)), 1'b1);
            if (i < 20) begin
                checks++;
                if (s_in_ready !== 1'b1) begin failures++; $display("FAIL tp_ready: cycle %0d got %b want 1", i, s_in_ready); end
            end
            if (i >= 2) begin
                checks++;
                if (s_out_valid !== 1'b1) begin failures++; $display("FAIL tp_valid: cycle %0d got %b want 1", i, s_out_valid); end
            end
        end
        checks += 2;
        if (n_out - out0 != 20) begin failures++; $display("FAIL tp_outputs: got %0d want 20", n_out - out0); end
        if (Blk_Cnt !== cnt0 + 16'd20) begin failures++; $display("FAIL tp_cnt: got %0d want %0d", Blk_Cnt, cnt0 + 16'd20); end
    endtask

    task automatic test_backpressure();
        bit           saw_block;
        bit           have_hold;
        logic [127:0] held;
        saw_block = 0;
        have_hold = 0;
        held      = '0;
        for (int i = 0; i < 12; i++) begin
            run_cycle(1'b0, 4'd0, '0, 1'b1, rnd128(), 4'($urandom_range(0, 14)), !(i >= 4 && i < 9));
            if (i >= 4 && i < 9) begin
                if (!s_in_ready) saw_block = 1;
                if (have_hold) begin
                    checks++;
                    if (s_out_data !== held) begin failures++; $display("FAIL bp_stable: got %h want %h", s_out_data, held); end
                end
                if (s_out_valid) begin
                    held      = s_out_data;
                    have_hold = 1;
                end
            end
        end
        checks++;
        if (!saw_block) begin failures++; $display("FAIL bp_ready_drop: got in_ready always 1 want a drop"); end
        drain();
    endtask

    task automatic test_bypass();
        run_cycle(1'b1, 4'd3, ONES, 1'b1, '0, 4'd3, 1'b1);
        idle(1'b1);
        #1;
        checks += 2;
        if (Out_Valid !== 1'b1) begin failures++; $display("FAIL byp_valid: got %b want 1", Out_Valid); end
        if (Out_Data !== ONES)  begin failures++; $display("FAIL byp_data: got %h want %h", Out_Data, ONES); end
        drain();
    endtask

    task automatic test_out_of_range();
        logic [127:0] d;
        d = rnd128();
        run_cycle(1'b1, 4'd15, rnd128(), 1'b0, '0, 4'd0, 1'b1);
        run_cycle(1'b0, 4'd0, '0, 1'b1, d, 4'd15, 1'b1);
        drain();
        checks++;
        if (last_out !== d) begin failures++; $display("FAIL oor_pass: got %h want %h", last_out, d); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            run_cycle(($urandom % 4) == 0, 4'($urandom_range(0, 15)), rnd128(),
                      $urandom % 2, rnd128(), 4'($urandom_range(0, 15)), ($urandom % 10) < 7);
        end
        drain();
        checks++;
        if (Blk_Cnt !== cnt_model) begin failures++; $display("FAIL rnd_cnt: got %0d want %0d", Blk_Cnt, cnt_model); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] d;
        bit           exp_err;
        do_reset();
        for (int i = 0; i < 15; i++) run_cycle(1'b1, 4'(i), rnd128(), 1'b0, '0, 4'd0, 1'b1);
        run_cycle(1'b0, 4'd0, '0, 1'b1, rnd128(), 4'd1, 1'b0);
        run_cycle(1'b0, 4'd0, '0, 1'b1, rnd128(), 4'd2, 1'b0);
        #1;
        Rst_n = 1'b0;
        In_Valid = 1'b0;
        model_clear();
        #1;
        checks += 2;
        if (Out_Valid !== 1'b0) begin failures++; $display("FAIL mid_valid: got %b want 0", Out_Valid); end
        if (Blk_Cnt !== 16'd0)  begin failures++; $display("FAIL mid_cnt: got %0d want 0", Blk_Cnt); end
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        d = rnd128();
        run_cycle(1'b0, 4'd0, '0, 1'b1, d, 4'd0, 1'b1);
        drain();
        checks++;
        if (last_out !== d) begin failures++; $display("FAIL mid_slot0: got %h want %h", last_out, d); end
        run_cycle(1'b0, 4'd0, '0, 1'b1, rnd128(), 4'd5, 1'b1);
        drain();
        for (int i = 0; i < 3; i++) idle(1'b1);
`ifdef ARK_KEYCHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        checks++;
        if (Key_Err !== exp_err) begin failures++; $display("FAIL keychk_sticky: got %b want %b", Key_Err, exp_err); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        n_out    = 0;
        last_out = '0;
        test_reset();
        test_fips();
        test_throughput();
        test_backpressure();
        test_bypass();
        test_out_of_range();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
